// File: rtl/ssp_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the TX arbiter and the SSP write port.
// master = arbiter side, slave = requesters/SSP side.
interface ssp_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic              SSPTXINTR;
    logic              PSEL;
    logic              PWRITE;
    logic [7:0]        PWDATA;
    logic              stall_err;
    logic              err_clr;

    modport master (
        input  req_valid, req_data, req_last, SSPTXINTR, err_clr,
        output req_ready, grant, PSEL, PWRITE, PWDATA, stall_err
    );
    modport slave (
        output req_valid, req_data, req_last, SSPTXINTR, err_clr,
        input  req_ready, grant, PSEL, PWRITE, PWDATA, stall_err
    );
endinterface

// File: rtl/ssp_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing the SSP TX write port among NREQ byte streams.
// Optional macro SSP_ARB_PRIO_EN: requester 0 always wins in IDLE, the others stay round-robin.
module ssp_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input logic              PCLK,
    input logic              CLEAR,
    ssp_tx_arbiter_if.master bus
);
    localparam int               IDX_W    = $clog2(NREQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt, rr_ptr, rr_nxt, pick, nxt_idx;
    logic [IDX_W:0]   probe;
    logic [CNT_W-1:0] stall_cnt, stall_nxt;
    logic             pick_vld, own_valid, own_last, stalled, abort, accept, consume, rel;
    logic             err_set, err_q;
    logic [7:0]       own_data;

    assign own_valid = bus.req_valid[owner];
    assign own_last  = bus.req_last[owner];
    assign own_data  = bus.req_data[{owner, 3'b000} +: 8];
    assign stalled   = (state == XFER) && own_valid && bus.SSPTXINTR;
    // The TIMEOUT-th stalled cycle aborts; its byte is discarded as the first drained byte.
    assign abort     = stalled && (stall_cnt == TMO - 1'b1);
    assign accept    = (state == XFER) && own_valid && !bus.SSPTXINTR;
    assign consume   = accept || ((state == DRAIN || abort) && own_valid);
    assign rel       = consume && own_last;
    assign nxt_idx   = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    always_comb begin
        bus.grant     = '0;
        bus.req_ready = '0;
        if (state != IDLE) begin
            bus.grant[owner]     = 1'b1;
            bus.req_ready[owner] = consume;
        end
    end

    assign bus.PSEL      = accept;
    assign bus.PWRITE    = accept;
    assign bus.PWDATA    = accept ? own_data : 8'h00;
    assign bus.stall_err = err_q;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        probe    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            probe = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (probe >= (IDX_W+1)'(NREQ))
                probe = probe - (IDX_W+1)'(NREQ);
            if (bus.req_valid[probe[IDX_W-1:0]]) begin
                pick     = probe[IDX_W-1:0];
                pick_vld = 1'b1;
            end
        end
`ifdef SSP_ARB_PRIO_EN
        if (bus.req_valid[0]) begin
            pick     = '0;
            pick_vld = 1'b1;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        stall_nxt = '0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = XFER;
                    owner_nxt = pick;
                end
            end
            XFER, DRAIN: begin
                err_set = abort;
                if (rel) begin
                    state_nxt = IDLE;
`ifdef SSP_ARB_PRIO_EN
                    if (owner != '0)
                        rr_nxt = nxt_idx;
`else
                    rr_nxt = nxt_idx;
`endif
                end else if (abort) begin
                    state_nxt = DRAIN;
                end else if (state == XFER && !accept) begin
                    // An owner that dropped valid holds the count rather than advancing it.
                    stall_nxt = stalled ? stall_cnt + 1'b1 : stall_cnt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            rr_ptr    <= rr_nxt;
            stall_cnt <= stall_nxt;
            if (err_set)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ssp_tx_arbiter.sv
// Directed bench for ssp_tx_arbiter: vector table for per-cycle behaviour plus hand sequences
// for timeout, asynchronous reset mid-packet and (when built with it) requester-0 priority.
module tb_ssp_tx_arbiter;
    localparam int NREQ = 4;

    logic PCLK = 1'b0;
    logic CLEAR;

    ssp_tx_arbiter_if #(.NREQ(NREQ)) bus ();
    ssp_tx_arbiter_if #(.NREQ(NREQ)) bus4 ();

    ssp_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(8), .CNT_W(8)) u_dut (
        .PCLK(PCLK), .CLEAR(CLEAR), .bus(bus)
    );
    ssp_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(4), .CNT_W(8)) u_dut_t4 (
        .PCLK(PCLK), .CLEAR(CLEAR), .bus(bus4)
    );

    // The short-timeout instance sees the same requesters and SSP status.
    assign bus4.req_valid = bus.req_valid;
    assign bus4.req_data  = bus.req_data;
    assign bus4.req_last  = bus.req_last;
    assign bus4.SSPTXINTR = bus.SSPTXINTR;
    assign bus4.err_clr   = bus.err_clr;

    always #5 PCLK = ~PCLK;

    typedef struct {
        bit          rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        intr;
        logic [3:0]  e_ready;
        logic [3:0]  e_grant;
        logic        e_psel;
        logic [7:0]  e_wdata;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rst, logic [3:0] v, logic [31:0] d, logic [3:0] l, logic intr,
                                logic [3:0] er, logic [3:0] eg, logic ep, logic [7:0] ew);
        vec_t t;
        t.rst = rst; t.valid = v; t.data = d; t.last = l; t.intr = intr;
        t.e_ready = er; t.e_grant = eg; t.e_psel = ep; t.e_wdata = ew;
        return t;
    endfunction

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l, input logic intr);
        bus.req_valid = v;
        bus.req_data  = d;
        bus.req_last  = l;
        bus.SSPTXINTR = intr;
    endtask

    // Called at a negedge; reset is pulsed and released well before the next posedge.
    task automatic do_reset();
        drive(4'b0, 32'h0, 4'b0, 1'b0);
        bus.err_clr = 1'b0;
        CLEAR = 1'b1;
        #1;
        CLEAR = 1'b0;
        #1;
    endtask

    task automatic run_row(input int r, input vec_t t);
        if (t.rst) do_reset();
        drive(t.valid, t.data, t.last, t.intr);
        #2;
        chk($sformatf("row%0d req_ready", r), bus.req_ready, t.e_ready);
        chk($sformatf("row%0d grant", r),     bus.grant,     t.e_grant);
        chk($sformatf("row%0d PSEL", r),      bus.PSEL,      t.e_psel);
        chk($sformatf("row%0d PWRITE", r),    bus.PWRITE,    t.e_psel);
        chk($sformatf("row%0d PWDATA", r),    bus.PWDATA,    t.e_wdata);
        @(negedge PCLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         b;
        int         lane;
        logic [3:0] g;
        CLEAR = 1'b1;
        bus.err_clr = 1'b0;
        drive(4'b1111, 32'hFFFF_FFFF, 4'b1111, 1'b0);
        #3;
        chk("reset grant",     bus.grant,      0);
        chk("reset req_ready", bus.req_ready,  0);
        chk("reset PSEL",      bus.PSEL,       0);
        chk("reset PWRITE",    bus.PWRITE,     0);
        chk("reset PWDATA",    bus.PWDATA,     0);
        chk("reset stall_err", bus.stall_err,  0);
        chk("reset grant t4",  bus4.grant,     0);
        @(negedge PCLK);

        // Single 3-byte packet on lane 0.
        tbl.push_back(mk(1, 4'b0001, 32'h0000_00A1, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00));
        tbl.push_back(mk(0, 4'b0001, 32'h0000_00A1, 4'b0000, 0, 4'b0001, 4'b0001, 1, 8'hA1));
        tbl.push_back(mk(0, 4'b0001, 32'h0000_00A2, 4'b0000, 0, 4'b0001, 4'b0001, 1, 8'hA2));
        tbl.push_back(mk(0, 4'b0001, 32'h0000_00A3, 4'b0001, 0, 4'b0001, 4'b0001, 1, 8'hA3));
        tbl.push_back(mk(0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00));
        // Lane 2 packet: owner drops valid for a cycle, then 5 cycles of FIFO full.
        tbl.push_back(mk(1, 4'b0100, 32'h00B1_0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00));
        tbl.push_back(mk(0, 4'b0100, 32'h00B1_0000, 4'b0000, 0, 4'b0100, 4'b0100, 1, 8'hB1));
        tbl.push_back(mk(0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 4'b0100, 0, 8'h00));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 4'b0100, 32'h00B2_0000, 4'b0000, 1, 4'b0000, 4'b0100, 0, 8'h00));
        tbl.push_back(mk(0, 4'b0100, 32'h00B2_0000, 4'b0000, 0, 4'b0100, 4'b0100, 1, 8'hB2));
        tbl.push_back(mk(0, 4'b0100, 32'h00B3_0000, 4'b0100, 0, 4'b0100, 4'b0100, 1, 8'hB3));
        tbl.push_back(mk(0, 4'b0000, 32'h0000_0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 8'h00));
        // All four lanes with 1-byte packets from reset; even rows are the IDLE gap.
        for (int i = 0; i < 10; i++) begin
`ifdef SSP_ARB_PRIO_EN
            lane = 0;
`else
            lane = (i / 2) % 4;
`endif
            g = 4'b0001 << lane;
            if (i % 2 == 1)
                tbl.push_back(mk(0, 4'b1111, 32'h1312_1110, 4'b1111, 0, g, g, 1, 8'(8'h10 + lane)));
            else
                tbl.push_back(mk(i == 0, 4'b1111, 32'h1312_1110, 4'b1111, 0, 4'b0000, 4'b0000, 0, 8'h00));
        end

        foreach (tbl[r]) run_row(r, tbl[r]);

        // Timeout on the TIMEOUT=4 instance: 6-byte packet on lane 0 with the FIFO held full.
        do_reset();
        b = 0;
        for (int c = 0; c < 12; c++) begin
            drive((b < 6) ? 4'b0001 : 4'b0000, {24'h0, 8'(8'hC0 + b)}, (b == 5) ? 4'b0001 : 4'b0000, 1'b1);
            bus.err_clr = (c == 10);
            #2;
            chk($sformatf("tmo c%0d grant", c),     bus4.grant,     (c >= 1 && c <= 9) ? 4'b0001 : 4'b0000);
            chk($sformatf("tmo c%0d req_ready", c), bus4.req_ready, (c >= 4 && c <= 9) ? 4'b0001 : 4'b0000);
            chk($sformatf("tmo c%0d PSEL", c),      bus4.PSEL,      0);
            chk($sformatf("tmo c%0d stall_err", c), bus4.stall_err, (c >= 5 && c <= 10) ? 1 : 0);
            if (bus4.req_ready[0]) b++;
            @(negedge PCLK);
        end
        bus.err_clr = 1'b0;
        chk("tmo bytes consumed", b, 6);

        // Asynchronous reset during byte 2 of a 4-byte lane-3 packet.
        do_reset();
        drive(4'b0010, 32'h0000_2100, 4'b0010, 1'b0);
        @(negedge PCLK);
        #2;
        chk("rst lane1 ready", bus.req_ready, 4'b0010);
        @(negedge PCLK);
        drive(4'b1000, 32'hD000_0000, 4'b0000, 1'b0);
        @(negedge PCLK);
        #2;
        chk("rst byte1 PWDATA", bus.PWDATA, 8'hD0);
        @(negedge PCLK);
        drive(4'b1000, 32'hD100_0000, 4'b0000, 1'b0);
        #2;
        chk("rst byte2 PSEL", bus.PSEL, 1);
        CLEAR = 1'b1;
        #1;
        chk("rst async PSEL",      bus.PSEL,      0);
        chk("rst async PWRITE",    bus.PWRITE,    0);
        chk("rst async grant",     bus.grant,     0);
        chk("rst async req_ready", bus.req_ready, 0);
        CLEAR = 1'b0;
        drive(4'b1010, 32'hD000_2100, 4'b1010, 1'b0);
        #1;
        chk("rst idle grant", bus.grant, 0);
        @(negedge PCLK);
        #2;
        chk("rst rr_ptr grant",  bus.grant,  4'b0010);
        chk("rst rr_ptr PWDATA", bus.PWDATA, 8'h21);
        @(negedge PCLK);

`ifdef SSP_ARB_PRIO_EN
        begin
            int         rem[4];
            int         order[$];
            logic [3:0] prev;
            logic [3:0] v, l;
            do_reset();
            rem = '{0, 2, 0, 0};
            prev = 4'b0;
            for (int c = 0; c < 10; c++) begin
                if (c == 1) begin rem[0] = 1; rem[2] = 1; end
                for (int i = 0; i < 4; i++) begin
                    v[i] = rem[i] > 0;
                    l[i] = rem[i] == 1;
                end
                drive(v, 32'h3332_3130, l, 1'b0);
                #2;
                if (bus.grant != 4'b0 && bus.grant != prev)
                    for (int i = 0; i < 4; i++) if (bus.grant[i]) order.push_back(i);
                prev = bus.grant;
                for (int i = 0; i < 4; i++) if (bus.req_ready[i]) rem[i]--;
                @(negedge PCLK);
            end
            chk("prio grant count", order.size(), 3);
            while (order.size() < 3) order.push_back(-1);
            chk("prio grant 1st", order[0], 1);
            chk("prio grant 2nd", order[1], 0);
            chk("prio grant 3rd", order[2], 2);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
